// File: rtl/key_event_pkg.sv
// Shared types and constants for the PS/2 set-2 key event decoder.
package key_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard status/acknowledge bytes that never start a key sequence
    localparam int NUM_IGNORE = 6;
    localparam logic [7:0] IGNORE_BYTES [NUM_IGNORE] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_IGNORE; i++) begin
            if (b == IGNORE_BYTES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Turns a stream of PS/2 set-2 scan bytes into per-key held state and
// single-cycle make/break event pulses.
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid
);

    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  skip_cnt;
    logic [16:0] to_cnt;

    // A received byte always wins over the timeout; the timeout only runs
    // while a prefix is pending and drops back to IDLE without an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            key_down    <= 512'b0;
            last_change <= 9'h000;
            key_valid   <= 1'b0;
            skip_cnt    <= 3'd0;
            to_cnt      <= 17'd0;
        end else begin
            key_valid <= 1'b0;
            if (rx_valid) begin
                to_cnt <= 17'd0;
                unique case (state)
                    ST_IDLE: begin
                        if (rx_data == PFX_EXT) begin
                            state <= ST_EXT;
                        end else if (rx_data == PFX_BRK) begin
                            state <= ST_BRK;
                        end else if (rx_data == PFX_PAUSE) begin
                            state    <= ST_SKIP;
                            skip_cnt <= PAUSE_SKIP;
                        end else if (!is_ignored(rx_data)) begin
                            key_down[{1'b0, rx_data}] <= 1'b1;
                            last_change <= {1'b0, rx_data};
                            key_valid   <= 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (rx_data == PFX_BRK) begin
                            state <= ST_EXT_BRK;
                        end else if (rx_data != PFX_EXT) begin
                            key_down[{1'b1, rx_data}] <= 1'b1;
                            last_change <= {1'b1, rx_data};
                            key_valid   <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        if (rx_data != PFX_BRK) begin
                            key_down[{state == ST_EXT_BRK, rx_data}] <= 1'b0;
                            last_change <= {state == ST_EXT_BRK, rx_data};
                            key_valid   <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    ST_SKIP: begin
                        if (skip_cnt == 3'd1) begin
                            state    <= ST_IDLE;
                            skip_cnt <= 3'd0;
                        end else begin
                            skip_cnt <= skip_cnt - 3'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (to_cnt == TO_LAST) begin
                    state    <= ST_IDLE;
                    skip_cnt <= 3'd0;
                    to_cnt   <= 17'd0;
                end else begin
                    to_cnt <= to_cnt + 17'd1;
                end
            end
        end
    end

endmodule
